// File: rtl/g3f_pkg.sv
// g3f_pkg -- shared types and defaults for the three-phase gate driver slice.
//   leg_st_t        : per-leg commutation state
//   G3F_DT_W        : default width of the dead-time count
//   G3F_SYNC_STAGES : default depth of the input synchronisers
package g3f_pkg;

  typedef enum logic [2:0] {
    OFF,    // both gates off, waiting for enable with no fault
    LO,     // low-side gate on
    DT_HI,  // dead time before turning the high side on
    HI,     // high-side gate on
    DT_LO   // dead time before turning the low side on
  } leg_st_t;

  localparam int unsigned G3F_DT_W        = 8;
  localparam int unsigned G3F_SYNC_STAGES = 2;

endpackage

// File: rtl/dt_leg.sv
// dt_leg -- one half-bridge leg: commutation FSM, dead-time counter and
// registered gate outputs. H and L are decoded from the state being entered,
// so they change on the same edge as the state and can never both be 1.
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   run        : 1 = leg may operate (enable synchronised and no latched fault);
//                0 = leg is forced to OFF on the next edge
//   cmd        : synchronised phase command (1 = high side, 0 = low side)
//   dt         : dead time in clock cycles minus one, sampled on load only
//   h, l       : registered high-side / low-side gate
module dt_leg
  import g3f_pkg::*;
#(
  parameter int unsigned DT_W = G3F_DT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            cmd,
  input  logic [DT_W-1:0] dt,
  output logic            h,
  output logic            l
);

  leg_st_t         st;
  logic [DT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= OFF;
      cnt <= '0;
      h   <= 1'b0;
      l   <= 1'b0;
    end else if (!run) begin
      st  <= OFF;
      cnt <= '0;
      h   <= 1'b0;
      l   <= 1'b0;
    end else begin
      case (st)
        OFF: begin
          // start-up always goes through a full dead-time interval
          st  <= cmd ? DT_HI : DT_LO;
          cnt <= dt;
          h   <= 1'b0;
          l   <= 1'b0;
        end

        LO: begin
          if (cmd) begin
            st  <= DT_HI;
            cnt <= dt;
            h   <= 1'b0;
            l   <= 1'b0;
          end else begin
            h   <= 1'b0;
            l   <= 1'b1;
          end
        end

        HI: begin
          if (!cmd) begin
            st  <= DT_LO;
            cnt <= dt;
            h   <= 1'b0;
            l   <= 1'b0;
          end else begin
            h   <= 1'b1;
            l   <= 1'b0;
          end
        end

        DT_HI: begin
          // an aborted request returns straight to LO: H was never driven
          if (!cmd) begin
            st <= LO;
            h  <= 1'b0;
            l  <= 1'b1;
          end else if (cnt == '0) begin
            st <= HI;
            h  <= 1'b1;
            l  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
            h   <= 1'b0;
            l   <= 1'b0;
          end
        end

        DT_LO: begin
          if (cmd) begin
            st <= HI;
            h  <= 1'b1;
            l  <= 1'b0;
          end else if (cnt == '0) begin
            st <= LO;
            h  <= 1'b0;
            l  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
            h   <= 1'b0;
            l   <= 1'b0;
          end
        end

        default: begin
          st  <= OFF;
          cnt <= '0;
          h   <= 1'b0;
          l   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dead_time_3f.sv
// dead_time_3f -- three-phase complementary gate driver with programmable
// dead time, enable gating and latched fault shutdown.
//
// Ports:
//   CLK, RSTn      : system clock (rising edge), asynchronous active-low reset
//   P0, P1, P2     : asynchronous phase commands (1 = high side, 0 = low side)
//   EN             : asynchronous driver enable, synchronised like P0..P2
//   DT [DT_W]      : dead time in CLK cycles minus one
//   FAULT          : external fault, active-high; masks all gates immediately
//   CLR_FLT        : synchronous clear of the latched fault (ignored while FAULT=1)
//   HA/LA, HB/LB,
//   HC/LC          : high-side / low-side gates of phases A, B, C
//   FLT            : latched fault flag
module dead_time_3f
  import g3f_pkg::*;
#(
  parameter int unsigned DT_W        = G3F_DT_W,
  parameter int unsigned SYNC_STAGES = G3F_SYNC_STAGES
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            P0,
  input  logic            P1,
  input  logic            P2,
  input  logic            EN,
  input  logic [DT_W-1:0] DT,
  input  logic            FAULT,
  input  logic            CLR_FLT,
  output logic            HA,
  output logic            LA,
  output logic            HB,
  output logic            LB,
  output logic            HC,
  output logic            LC,
  output logic            FLT
);

  // fewer than two stages would not resolve metastability
  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // bit 3 = EN, bits 2..0 = P2..P0
  logic [3:0] sync_q [SYNC_N];
  logic [3:0] sync_out;
  logic       en_s;
  logic       flt_q;
  logic       run;
  logic       ha_q, la_q, hb_q, lb_q, hc_q, lc_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int unsigned i = 0; i < SYNC_N; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= {EN, P2, P1, P0};
      for (int unsigned i = 1; i < SYNC_N; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_N-1];
  assign en_s     = sync_out[3];

  // FAULT has priority over CLR_FLT
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      flt_q <= 1'b0;
    end else if (FAULT) begin
      flt_q <= 1'b1;
    end else if (CLR_FLT) begin
      flt_q <= 1'b0;
    end
  end

  assign FLT = flt_q;
  assign run = en_s & ~flt_q;

  dt_leg #(.DT_W(DT_W)) u_leg_a (
    .clk   (CLK),
    .rst_n (RSTn),
    .run   (run),
    .cmd   (sync_out[0]),
    .dt    (DT),
    .h     (ha_q),
    .l     (la_q)
  );

  dt_leg #(.DT_W(DT_W)) u_leg_b (
    .clk   (CLK),
    .rst_n (RSTn),
    .run   (run),
    .cmd   (sync_out[1]),
    .dt    (DT),
    .h     (hb_q),
    .l     (lb_q)
  );

  dt_leg #(.DT_W(DT_W)) u_leg_c (
    .clk   (CLK),
    .rst_n (RSTn),
    .run   (run),
    .cmd   (sync_out[2]),
    .dt    (DT),
    .h     (hc_q),
    .l     (lc_q)
  );

  // clock-independent kill path: FAULT removes every gate in the same cycle
  assign HA = ha_q & ~FAULT;
  assign LA = la_q & ~FAULT;
  assign HB = hb_q & ~FAULT;
  assign LB = lb_q & ~FAULT;
  assign HC = hc_q & ~FAULT;
  assign LC = lc_q & ~FAULT;

endmodule

// File: tb/tb_dead_time_3f.sv
module tb_dead_time_3f;

  localparam int SYNC = 2;

  logic       CLK = 1'b0;
  logic       RSTn, P0, P1, P2, EN, FAULT, CLR_FLT;
  logic [7:0] DT;
  logic       HA, LA, HB, LB, HC, LC, FLT;

  int total = 0;
  int bad   = 0;

  dead_time_3f #(.DT_W(8), .SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .RSTn(RSTn), .P0(P0), .P1(P1), .P2(P2), .EN(EN), .DT(DT),
    .FAULT(FAULT), .CLR_FLT(CLR_FLT),
    .HA(HA), .LA(LA), .HB(HB), .LB(LB), .HC(HC), .LC(LC), .FLT(FLT)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. Each leg has a side it is driving (0 none, 1 low, 2 high)
  // and optionally a pending side with a remaining gap count; while a side is
  // pending nothing is driven.
  logic [3:0] sq [SYNC];
  bit         flt_m;
  int         drive [3];
  int         pend  [3];
  int         left  [3];

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) sq[i] = '0;
    flt_m = 0;
    for (int l = 0; l < 3; l++) begin
      drive[l] = 0; pend[l] = 0; left[l] = 0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] so;
    bit run;
    int want;
    so  = sq[SYNC-1];
    run = so[3] && !flt_m;
    for (int l = 0; l < 3; l++) begin
      want = so[l] ? 2 : 1;
      if (!run) begin
        drive[l] = 0; pend[l] = 0;
      end else if (pend[l] != 0) begin
        if (want != pend[l]) begin
          drive[l] = want; pend[l] = 0;
        end else if (left[l] == 0) begin
          drive[l] = pend[l]; pend[l] = 0;
        end else begin
          left[l] = left[l] - 1;
        end
      end else if (drive[l] != want) begin
        pend[l] = want; left[l] = int'(DT);
      end
    end
    if (FAULT) flt_m = 1;
    else if (CLR_FLT) flt_m = 0;
    for (int i = SYNC - 1; i > 0; i--) sq[i] = sq[i-1];
    sq[0] = {EN, P2, P1, P0};
  endtask

  task automatic check_outputs();
    logic [2:0] hv, lv;
    int o;
    hv = {HC, HB, HA};
    lv = {LC, LB, LA};
    for (int l = 0; l < 3; l++) begin
      o = (pend[l] != 0) ? 0 : drive[l];
      check_eq($sformatf("H%0d", l), 32'(hv[l]), 32'((o == 2) && !FAULT));
      check_eq($sformatf("L%0d", l), 32'(lv[l]), 32'((o == 1) && !FAULT));
      check_eq($sformatf("HL_excl%0d", l), 32'(hv[l] & lv[l]), 32'd0);
    end
    check_eq("FLT", 32'(FLT), 32'(flt_m));
  endtask

  task automatic tick();
    if (RSTn) model_edge();
    else model_reset();
    @(posedge CLK);
    #1;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic flip(input int l);
    case (l)
      0: P0 = ~P0;
      1: P1 = ~P1;
      default: P2 = ~P2;
    endcase
  endtask

  function automatic logic [1:0] leg_gates(input int l);
    case (l)
      0: return {HA, LA};
      1: return {HB, LB};
      default: return {HC, LC};
    endcase
  endfunction

  // Counts the cycles with both gates of a leg low, ending when a gate comes
  // back on after a gap. gap = -1 if the budget runs out.
  task automatic measure_gap(input int l, input int budget, input int chg_at,
                             input logic [7:0] chg_dt, output int gap);
    int n;
    bit done;
    gap  = 0;
    done = 0;
    for (n = 0; n < budget && !done; n++) begin
      if (n == chg_at) DT = chg_dt;
      tick();
      if (leg_gates(l) == 2'b00) gap++;
      else if (gap > 0) done = 1;
    end
    if (!done) gap = -1;
  endtask

  logic [2:0] six_step [6];
  logic [2:0] prev, cur;
  int g, n, lb_low, hb_hi;

  initial begin
    six_step[0] = 3'b001; six_step[1] = 3'b011; six_step[2] = 3'b010;
    six_step[3] = 3'b110; six_step[4] = 3'b100; six_step[5] = 3'b101;

    RSTn = 0; P0 = 0; P1 = 0; P2 = 0; EN = 0; FAULT = 0; CLR_FLT = 0; DT = 8'd3;
    model_reset();
    #2;

    // reset: phase activity must not reach the gates
    for (int i = 0; i < 6; i++) begin
      {P2, P1, P0} = 3'(i);
      EN = 1;
      tick();
    end

    // release with EN=1, DT=3, P0=1
    P0 = 1; P1 = 0; P2 = 0; DT = 8'd3;
    RSTn = 1;
    for (n = 1; n <= 50; n++) begin
      tick();
      if (HA) break;
    end
    check_eq("start_lat", 32'(n), 32'(SYNC + 3 + 2));
    ticks(10);

    // six-step commutation with DT=4: every edge gives a 5-cycle gap
    DT = 8'd4;
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 6; s++) begin
        prev = {P2, P1, P0};
        cur  = six_step[s];
        {P2, P1, P0} = cur;
        for (int l = 0; l < 3; l++) begin
          if (prev[l] != cur[l]) begin
            measure_gap(l, 60, -1, 8'd0, g);
            check_eq($sformatf("six_gap%0d", l), 32'(g), 32'd5);
          end
        end
        ticks(8);
      end
    end

    // glitch: P1 high for 2 cycles with DT=10
    DT = 8'd10;
    P1 = 0;
    ticks(20);
    P1 = 1;
    ticks(2);
    P1 = 0;
    lb_low = 0; hb_hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!LB) lb_low++;
      if (HB) hb_hi++;
    end
    check_eq("glitch_lb_low", 32'(lb_low), 32'd2);
    check_eq("glitch_hb", 32'(hb_hi), 32'd0);

    // fault mid-HI
    DT = 8'd2;
    P0 = 1; P1 = 1; P2 = 1;
    ticks(15);
    FAULT = 1;
    #1;
    check_outputs();
    check_eq("fault_kill", 32'({HA, HB, HC}), 32'd0);
    tick();
    CLR_FLT = 1;
    ticks(2);
    check_eq("flt_hold", 32'(FLT), 32'd1);
    FAULT = 0; CLR_FLT = 0;
    tick();
    CLR_FLT = 1;
    tick();
    CLR_FLT = 0;
    measure_gap(0, 30, -1, 8'd0, g);
    check_eq("restart_gap", 32'(g), 32'd3);
    ticks(5);

    // DT=0: one-cycle gap both ways
    DT = 8'd0;
    P2 = 0;
    measure_gap(2, 30, -1, 8'd0, g);
    check_eq("dt0_fall", 32'(g), 32'd1);
    ticks(4);
    P2 = 1;
    measure_gap(2, 30, -1, 8'd0, g);
    check_eq("dt0_rise", 32'(g), 32'd1);
    ticks(4);

    // DT=255 changed to 2 mid-count
    DT = 8'd255;
    P0 = 0;
    measure_gap(0, 400, 6, 8'd2, g);
    check_eq("dt255_gap", 32'(g), 32'd256);
    ticks(4);
    P0 = 1;
    measure_gap(0, 40, -1, 8'd0, g);
    check_eq("dt2_gap", 32'(g), 32'd3);
    ticks(4);

    // randomized mix of commutation, glitches, DT, EN and fault events
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 11))
        0, 1, 2, 3, 4, 5: flip(int'($urandom_range(0, 2)));
        6: DT = 8'($urandom_range(0, 6));
        7: EN = ~EN;
        8: begin
          FAULT = 1;
          CLR_FLT = 1'($urandom_range(0, 1));
          #1;
          check_outputs();
          ticks(int'($urandom_range(1, 3)));
          FAULT = 0;
          tick();
          CLR_FLT = 1;
          tick();
          CLR_FLT = 0;
        end
        9: begin
          int l;
          l = int'($urandom_range(0, 2));
          flip(l);
          ticks(int'($urandom_range(1, 3)));
          flip(l);
        end
        10: begin
          {P2, P1, P0} = 3'($urandom_range(0, 7));
        end
        default: EN = 1;
      endcase
      ticks(int'($urandom_range(1, 12)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
